// File: rtl/vga_sync_receiver.sv
// VGA timing receiver: recovers pixel coordinates and data-enable from active-low
// hsync/vsync, measures line/frame periods and locks onto the configured timing.
module vga_sync_receiver #(
  parameter int H_VISIBLE   = 640,
  parameter int H_FRONT     = 16,
  parameter int H_SYNC      = 96,
  parameter int H_BACK      = 48,
  parameter int V_VISIBLE   = 480,
  parameter int V_FRONT     = 10,
  parameter int V_SYNC      = 2,
  parameter int V_BACK      = 33,
  parameter int LOCK_FRAMES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        hsync_in,
  input  logic        vsync_in,
  output logic [10:0] x_pos,
  output logic [10:0] y_pos,
  output logic        de,
  output logic        frame_start,
  output logic        locked,
  output logic        h_err,
  output logic        v_err,
  output logic [11:0] meas_h_total,
  output logic [10:0] meas_v_total
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int CNT_W   = $clog2(LOCK_FRAMES + 1);

  localparam logic [11:0]      H_TOTAL_C = 12'(H_TOTAL);
  localparam logic [11:0]      H_ACT_LO  = 12'(H_SYNC + H_BACK);
  localparam logic [11:0]      H_ACT_HI  = 12'(H_SYNC + H_BACK + H_VISIBLE - 1);
  localparam logic [10:0]      X_OFS     = 11'(H_SYNC + H_BACK);
  localparam logic [10:0]      V_TOTAL_C = 11'(V_TOTAL);
  localparam logic [10:0]      V_ACT_LO  = 11'(V_SYNC + V_BACK);
  localparam logic [10:0]      V_ACT_HI  = 11'(V_SYNC + V_BACK + V_VISIBLE - 1);
  localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(LOCK_FRAMES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};

  typedef enum logic [1:0] {
    ST_UNLOCKED = 2'd0,
    ST_CHECKING = 2'd1,
    ST_LOCKED   = 2'd2
  } state_t;

  logic             hs_d1_r, hs_d2_r, vs_d1_r, vs_d2_r;
  logic [11:0]      h_phase_r;
  logic [10:0]      v_line_r;
  logic             h_seen_r, vs_pending_r, bad_frame_r;
  state_t           state_r, state_s;
  logic [CNT_W-1:0] good_cnt_r, good_cnt_s;

  logic        hs_fall_s, vs_fall_s, boundary_s, h_sat_s;
  logic        line_bad_s, v_bad_s, frame_good_s, act_s, lock_next_s;
  logic [11:0] h_len_s;
  logic [10:0] v_len_s;

  assign hs_fall_s    = hs_d2_r & ~hs_d1_r;
  assign vs_fall_s    = vs_d2_r & ~vs_d1_r;
  assign boundary_s   = hs_fall_s & (vs_pending_r | vs_fall_s);
  assign h_sat_s      = (h_phase_r == 12'hFFF);
  // measured lengths saturate so a stalled hsync still reads as a bad line
  assign h_len_s      = h_sat_s ? 12'hFFF : h_phase_r + 12'd1;
  assign v_len_s      = (v_line_r == 11'h7FF) ? 11'h7FF : v_line_r + 11'd1;
  assign line_bad_s   = hs_fall_s & h_seen_r & (h_len_s != H_TOTAL_C);
  assign v_bad_s      = (v_len_s != V_TOTAL_C);
  assign frame_good_s = ~v_bad_s & ~bad_frame_r & ~line_bad_s;
  assign act_s        = (h_phase_r >= H_ACT_LO) && (h_phase_r <= H_ACT_HI) &&
                        (v_line_r >= V_ACT_LO) && (v_line_r <= V_ACT_HI);
  assign lock_next_s  = (state_s == ST_LOCKED);

  // Input sync flops idle high so reset release never looks like a falling edge
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hs_d1_r <= 1'b1;
      hs_d2_r <= 1'b1;
      vs_d1_r <= 1'b1;
      vs_d2_r <= 1'b1;
    end else begin
      hs_d1_r <= hsync_in;
      hs_d2_r <= hs_d1_r;
      vs_d1_r <= vsync_in;
      vs_d2_r <= vs_d1_r;
    end
  end

  // Phase/line counters and period measurement
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      h_phase_r    <= 12'd0;
      v_line_r     <= 11'd0;
      h_seen_r     <= 1'b0;
      vs_pending_r <= 1'b0;
      bad_frame_r  <= 1'b0;
      meas_h_total <= 12'd0;
      meas_v_total <= 11'd0;
      h_err        <= 1'b0;
      v_err        <= 1'b0;
      frame_start  <= 1'b0;
    end else begin
      if (hs_fall_s) begin
        h_phase_r <= 12'd0;
        h_seen_r  <= 1'b1;
      end else if (!h_sat_s) begin
        h_phase_r <= h_phase_r + 12'd1;
      end
      if (hs_fall_s && h_seen_r) begin
        meas_h_total <= h_len_s;
        h_err        <= (h_len_s != H_TOTAL_C);
      end
      if (boundary_s) begin
        v_line_r     <= 11'd0;
        meas_v_total <= v_len_s;
        v_err        <= v_bad_s;
      end else if (hs_fall_s && (v_line_r != 11'h7FF)) begin
        v_line_r <= v_line_r + 11'd1;
      end
      // a stalled hsync also times out a pending vsync
      if (boundary_s) begin
        vs_pending_r <= 1'b0;
      end else if (vs_fall_s) begin
        vs_pending_r <= 1'b1;
      end else if (h_sat_s) begin
        vs_pending_r <= 1'b0;
      end
      if (boundary_s) begin
        bad_frame_r <= 1'b0;
      end else if (line_bad_s) begin
        bad_frame_r <= 1'b1;
      end
      frame_start <= boundary_s;
    end
  end

  // Lock state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r    <= ST_UNLOCKED;
      good_cnt_r <= CNT_ZERO;
    end else begin
      state_r    <= state_s;
      good_cnt_r <= good_cnt_s;
    end
  end

  // Lock next-state: the first boundary only arms checking
  always_comb begin
    state_s    = state_r;
    good_cnt_s = good_cnt_r;
    case (state_r)
      ST_UNLOCKED: begin
        if (boundary_s) begin
          state_s    = ST_CHECKING;
          good_cnt_s = CNT_ZERO;
        end else begin
          state_s = ST_UNLOCKED;
        end
      end
      ST_CHECKING: begin
        if (h_sat_s) begin
          state_s    = ST_UNLOCKED;
          good_cnt_s = CNT_ZERO;
        end else if (boundary_s && frame_good_s) begin
          good_cnt_s = good_cnt_r + CNT_ONE;
          if (good_cnt_r == LOCK_LAST) begin
            state_s = ST_LOCKED;
          end else begin
            state_s = ST_CHECKING;
          end
        end else if (boundary_s) begin
          good_cnt_s = CNT_ZERO;
        end else begin
          state_s = ST_CHECKING;
        end
      end
      ST_LOCKED: begin
        if (line_bad_s || (boundary_s && v_bad_s) || h_sat_s) begin
          state_s    = ST_UNLOCKED;
          good_cnt_s = CNT_ZERO;
        end else begin
          state_s = ST_LOCKED;
        end
      end
      default: begin
        state_s    = ST_UNLOCKED;
        good_cnt_s = CNT_ZERO;
      end
    endcase
  end

  // Registered video outputs; coordinates hold outside the active window
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      locked <= 1'b0;
      de     <= 1'b0;
      x_pos  <= 11'd0;
      y_pos  <= 11'd0;
    end else begin
      locked <= lock_next_s;
      de     <= lock_next_s && act_s;
      if (lock_next_s && act_s) begin
        x_pos <= h_phase_r[10:0] - X_OFS;
        y_pos <= v_line_r - V_ACT_LO;
      end
    end
  end

endmodule

// File: tb/tb_vga_sync_receiver.sv
// Directed bench for vga_sync_receiver using a reduced 16x11 timing so that
// lock/unlock sequences fit in a few thousand cycles.
module tb_vga_sync_receiver;

  localparam int HV = 8, HF = 2, HS = 3, HB = 3, HT = 16;
  localparam int VV = 6, VF = 1, VS = 2, VB = 2, VT = 11;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        hsync_in = 1'b1;
  logic        vsync_in = 1'b1;
  logic [10:0] x_pos, y_pos, meas_v_total;
  logic [11:0] meas_h_total;
  logic        de, frame_start, locked, h_err, v_err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  vga_sync_receiver #(
    .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB), .LOCK_FRAMES(2)
  ) dut (
    .clk(clk), .reset(reset), .hsync_in(hsync_in), .vsync_in(vsync_in),
    .x_pos(x_pos), .y_pos(y_pos), .de(de), .frame_start(frame_start),
    .locked(locked), .h_err(h_err), .v_err(v_err),
    .meas_h_total(meas_h_total), .meas_v_total(meas_v_total)
  );

  // Frame statistics and event capture, latched at each frame_start
  int   fs_cnt = 0, lock_fs = -1;
  logic lock_with_fs = 1'b0;
  logic locked_q = 1'b0, herr_q = 1'b0, verr_q = 1'b0;
  int   cur_de = 0, cur_xs = 0, cur_ys = 0, cur_xmax = 0, cur_ymax = 0;
  int   prev_de = 0, prev_xs = 0, prev_ys = 0, prev_xmax = 0, prev_ymax = 0;
  int   herr_rises = 0, herr_meas = 0, verr_rises = 0, verr_meas = 0;
  logic herr_locked = 1'b1, verr_locked = 1'b1;

  always @(negedge clk) begin
    locked_q <= locked;
    herr_q   <= h_err;
    verr_q   <= v_err;
    if (frame_start) begin
      fs_cnt    <= fs_cnt + 1;
      prev_de   <= cur_de;
      prev_xs   <= cur_xs;
      prev_ys   <= cur_ys;
      prev_xmax <= cur_xmax;
      prev_ymax <= cur_ymax;
      cur_de    <= 0;
      cur_xs    <= 0;
      cur_ys    <= 0;
      cur_xmax  <= 0;
      cur_ymax  <= 0;
    end else if (de) begin
      cur_de   <= cur_de + 1;
      cur_xs   <= cur_xs + int'(x_pos);
      cur_ys   <= cur_ys + int'(y_pos);
      cur_xmax <= (int'(x_pos) > cur_xmax) ? int'(x_pos) : cur_xmax;
      cur_ymax <= (int'(y_pos) > cur_ymax) ? int'(y_pos) : cur_ymax;
    end
    if (locked && !locked_q) begin
      lock_fs      <= fs_cnt + (frame_start ? 1 : 0);
      lock_with_fs <= frame_start;
    end
    if (h_err && !herr_q) begin
      herr_rises  <= herr_rises + 1;
      herr_meas   <= int'(meas_h_total);
      herr_locked <= locked;
    end
    if (v_err && !verr_q) begin
      verr_rises  <= verr_rises + 1;
      verr_meas   <= int'(meas_v_total);
      verr_locked <= locked;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      hsync_in = 1'b1;
      vsync_in = 1'b1;
      tick();
    end
  endtask

  // vsync is low from pixel vs_from onward (0 = whole line, >= n_pix = never)
  task automatic send_line(input int n_pix, input int vs_from);
    for (int p = 0; p < n_pix; p++) begin
      hsync_in = (p < HS) ? 1'b0 : 1'b1;
      vsync_in = (p >= vs_from) ? 1'b0 : 1'b1;
      tick();
    end
  endtask

  task automatic send_frame(input int n_lines, input int long_line, input bit early_vs);
    int vs_from;
    int n_pix;
    for (int l = 0; l < n_lines; l++) begin
      vs_from = 1000;
      if (l < VS) vs_from = 0;
      else if (early_vs && (l == n_lines - 1)) vs_from = 8;
      n_pix = (l == long_line) ? HT + 1 : HT;
      send_line(n_pix, vs_from);
    end
  endtask

  task automatic test_reset();
    repeat (3) tick();
    checks++; if (de !== 1'b0) begin errors++; $display("FAIL rst_de: got %0b expected 0", de); end
    checks++; if (locked !== 1'b0) begin errors++; $display("FAIL rst_locked: got %0b expected 0", locked); end
    checks++; if (frame_start !== 1'b0) begin errors++; $display("FAIL rst_fs: got %0b expected 0", frame_start); end
    checks++; if (x_pos !== 11'd0 || y_pos !== 11'd0) begin errors++; $display("FAIL rst_xy: got %0d/%0d expected 0/0", x_pos, y_pos); end
    checks++; if (h_err !== 1'b0 || v_err !== 1'b0) begin errors++; $display("FAIL rst_err: got %0b/%0b expected 0/0", h_err, v_err); end
    checks++; if (meas_h_total !== 12'd0 || meas_v_total !== 11'd0) begin errors++; $display("FAIL rst_meas: got %0d/%0d expected 0/0", meas_h_total, meas_v_total); end
    reset = 1'b0;
    idle(5);
  endtask

  task automatic test_nominal();
    int base;
    base = fs_cnt;
    send_frame(VT, -1, 1'b0);
    send_frame(VT, -1, 1'b0);
    send_frame(VT, -1, 1'b0);
    checks++; if (locked !== 1'b1) begin errors++; $display("FAIL nom_locked: got %0b expected 1", locked); end
    checks++; if (lock_fs !== base + 3) begin errors++; $display("FAIL nom_lock_boundary: got %0d expected %0d", lock_fs, base + 3); end
    checks++; if (lock_with_fs !== 1'b1) begin errors++; $display("FAIL nom_lock_timing: got %0b expected 1", lock_with_fs); end
    send_frame(VT, -1, 1'b0);
    checks++; if (prev_de !== HV * VV) begin errors++; $display("FAIL nom_de_count: got %0d expected %0d", prev_de, HV * VV); end
    checks++; if (prev_xs !== 168) begin errors++; $display("FAIL nom_x_sum: got %0d expected 168", prev_xs); end
    checks++; if (prev_ys !== 120) begin errors++; $display("FAIL nom_y_sum: got %0d expected 120", prev_ys); end
    checks++; if (prev_xmax !== HV - 1) begin errors++; $display("FAIL nom_x_max: got %0d expected %0d", prev_xmax, HV - 1); end
    checks++; if (prev_ymax !== VV - 1) begin errors++; $display("FAIL nom_y_max: got %0d expected %0d", prev_ymax, VV - 1); end
    checks++; if (meas_h_total !== 12'(HT)) begin errors++; $display("FAIL nom_meas_h: got %0d expected %0d", meas_h_total, HT); end
    checks++; if (meas_v_total !== 11'(VT)) begin errors++; $display("FAIL nom_meas_v: got %0d expected %0d", meas_v_total, VT); end
    checks++; if (h_err !== 1'b0 || v_err !== 1'b0) begin errors++; $display("FAIL nom_err: got %0b/%0b expected 0/0", h_err, v_err); end
  endtask

  task automatic test_long_line();
    int rises;
    int base;
    rises = herr_rises;
    send_frame(VT, 3, 1'b0);
    checks++; if (herr_rises !== rises + 1) begin errors++; $display("FAIL line_herr_rise: got %0d expected %0d", herr_rises, rises + 1); end
    checks++; if (herr_meas !== HT + 1) begin errors++; $display("FAIL line_meas_h: got %0d expected %0d", herr_meas, HT + 1); end
    checks++; if (herr_locked !== 1'b0) begin errors++; $display("FAIL line_unlock: got %0b expected 0", herr_locked); end
    checks++; if (h_err !== 1'b0) begin errors++; $display("FAIL line_herr_clear: got %0b expected 0", h_err); end
    base = fs_cnt;
    send_frame(VT, -1, 1'b0);
    send_frame(VT, -1, 1'b0);
    send_frame(VT, -1, 1'b0);
    checks++; if (locked !== 1'b1 || lock_fs !== base + 3) begin errors++; $display("FAIL line_relock: got %0b at %0d expected 1 at %0d", locked, lock_fs, base + 3); end
  endtask

  task automatic test_long_frame();
    int rises;
    rises = verr_rises;
    send_frame(VT + 1, -1, 1'b0);
    send_frame(VT, -1, 1'b0);
    checks++; if (verr_rises !== rises + 1) begin errors++; $display("FAIL frame_verr_rise: got %0d expected %0d", verr_rises, rises + 1); end
    checks++; if (verr_meas !== VT + 1) begin errors++; $display("FAIL frame_meas_v: got %0d expected %0d", verr_meas, VT + 1); end
    checks++; if (verr_locked !== 1'b0) begin errors++; $display("FAIL frame_unlock: got %0b expected 0", verr_locked); end
    send_frame(VT, -1, 1'b0);
    checks++; if (v_err !== 1'b0) begin errors++; $display("FAIL frame_verr_clear: got %0b expected 0", v_err); end
    checks++; if (meas_v_total !== 11'(VT)) begin errors++; $display("FAIL frame_meas_v_clean: got %0d expected %0d", meas_v_total, VT); end
    checks++; if (locked !== 1'b0) begin errors++; $display("FAIL frame_still_unlocked: got %0b expected 0", locked); end
  endtask

  task automatic test_h_saturation();
    int base;
    send_frame(VT, -1, 1'b0);
    send_frame(VT, -1, 1'b0);
    checks++; if (locked !== 1'b1) begin errors++; $display("FAIL sat_pre_locked: got %0b expected 1", locked); end
    base = fs_cnt;
    for (int i = 0; i < 4200; i++) begin
      hsync_in = 1'b1;
      vsync_in = (i < 20) ? 1'b0 : 1'b1;
      tick();
    end
    checks++; if (locked !== 1'b0) begin errors++; $display("FAIL sat_locked: got %0b expected 0", locked); end
    checks++; if (de !== 1'b0) begin errors++; $display("FAIL sat_de: got %0b expected 0", de); end
    checks++; if (fs_cnt !== base) begin errors++; $display("FAIL sat_no_fs: got %0d expected %0d", fs_cnt, base); end
    send_line(HT, 1000);
    checks++; if (h_err !== 1'b1) begin errors++; $display("FAIL sat_gap_herr: got %0b expected 1", h_err); end
    send_line(HT, 1000);
    checks++; if (fs_cnt !== base) begin errors++; $display("FAIL sat_pending_timeout: got %0d expected %0d", fs_cnt, base); end
  endtask

  task automatic test_midline_vsync();
    int base;
    base = fs_cnt;
    send_frame(VT, -1, 1'b0);
    send_frame(VT, -1, 1'b1);
    send_frame(VT, -1, 1'b1);
    checks++; if (locked !== 1'b1 || lock_fs !== base + 3) begin errors++; $display("FAIL mid_lock: got %0b at %0d expected 1 at %0d", locked, lock_fs, base + 3); end
    send_frame(VT, -1, 1'b0);
    checks++; if (fs_cnt !== base + 4) begin errors++; $display("FAIL mid_fs_count: got %0d expected %0d", fs_cnt, base + 4); end
    checks++; if (prev_de !== HV * VV) begin errors++; $display("FAIL mid_de_count: got %0d expected %0d", prev_de, HV * VV); end
    checks++; if (prev_ys !== 120 || prev_ymax !== VV - 1) begin errors++; $display("FAIL mid_y: got sum %0d max %0d expected 120/%0d", prev_ys, prev_ymax, VV - 1); end
    checks++; if (meas_v_total !== 11'(VT) || v_err !== 1'b0) begin errors++; $display("FAIL mid_meas_v: got %0d/%0b expected %0d/0", meas_v_total, v_err, VT); end
  endtask

  task automatic test_reset_midframe();
    int base;
    for (int l = 0; l < 5; l++) send_line(HT, (l < VS) ? 0 : 1000);
    send_line(11, 1000);
    checks++; if (de !== 1'b1 || locked !== 1'b1) begin errors++; $display("FAIL rmid_pre: got de %0b locked %0b expected 1/1", de, locked); end
    reset = 1'b1;
    #1;
    checks++; if (de !== 1'b0 || locked !== 1'b0) begin errors++; $display("FAIL rmid_de_locked: got %0b/%0b expected 0/0", de, locked); end
    checks++; if (x_pos !== 11'd0 || y_pos !== 11'd0) begin errors++; $display("FAIL rmid_xy: got %0d/%0d expected 0/0", x_pos, y_pos); end
    checks++; if (meas_h_total !== 12'd0 || meas_v_total !== 11'd0) begin errors++; $display("FAIL rmid_meas: got %0d/%0d expected 0/0", meas_h_total, meas_v_total); end
    idle(2);
    reset = 1'b0;
    base = fs_cnt;
    idle(3);
    send_line(HT, 1000);
    checks++; if (meas_h_total !== 12'd0 || h_err !== 1'b0) begin errors++; $display("FAIL rmid_no_false_edge: got %0d/%0b expected 0/0", meas_h_total, h_err); end
    checks++; if (fs_cnt !== base) begin errors++; $display("FAIL rmid_no_fs: got %0d expected %0d", fs_cnt, base); end
    for (int l = 7; l < VT; l++) send_line(HT, 1000);
    send_frame(VT, -1, 1'b0);
    send_frame(VT, -1, 1'b0);
    checks++; if (locked !== 1'b0) begin errors++; $display("FAIL rmid_not_yet: got %0b expected 0", locked); end
    send_frame(VT, -1, 1'b0);
    checks++; if (locked !== 1'b1 || lock_fs !== base + 3) begin errors++; $display("FAIL rmid_relock: got %0b at %0d expected 1 at %0d", locked, lock_fs, base + 3); end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_long_line();
    test_long_frame();
    test_h_saturation();
    test_midline_vsync();
    test_reset_midframe();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/vga_sync_receiver.md
Name: vga_sync_receiver

Overview:
- Sink-side counterpart of the on-chip VGA timing generator: consumes active-low hsync/vsync, recovers pixel coordinates and data-enable, and measures line/frame periods.
- Checks measured timing against the 640x480@60 parameter set and reports lock and errors.
- Used in loopback self-test of the display path and as the front end for capturing a VGA-timed stream; inputs are synchronous to clk, one sample per clk = one pixel.

Parameters:
- H_VISIBLE, 640, active pixels per line
- H_FRONT, 16, horizontal front porch
- H_SYNC, 96, hsync pulse width
- H_BACK, 48, horizontal back porch
- V_VISIBLE, 480, active lines per frame
- V_FRONT, 10, vertical front porch
- V_SYNC, 2, vsync pulse width in lines
- V_BACK, 33, vertical back porch
- LOCK_FRAMES, 2, consecutive good frames required for lock
- (derived) H_TOTAL = 800, V_TOTAL = 525

Ports:
- clk  input  1  pixel clock
- reset  input  1  asynchronous, active-high reset
- hsync_in  input  1  horizontal sync, active low
- vsync_in  input  1  vertical sync, active low
- x_pos  output  11  recovered column, valid when de=1
- y_pos  output  11  recovered row, valid when de=1
- de  output  1  active-video enable, only while locked
- frame_start  output  1  one-cycle pulse at each frame boundary
- locked  output  1  timing matches parameters
- h_err  output  1  last measured line length != H_TOTAL
- v_err  output  1  last measured frame length != V_TOTAL
- meas_h_total  output  12  last measured clocks per line
- meas_v_total  output  11  last measured lines per frame

Behaviour:
- Reset: all outputs 0; both input sync flops reset to 1 (idle) so no false edge fires after reset; FSM = UNLOCKED; h_seen = 0; vs_pending = 0.
- Edge detect: hsync_in and vsync_in are each registered twice. hs_fall = (prev=1, cur=0); vs_fall likewise.
- h_phase (12 bit): 0 in the hs_fall cycle, else +1, saturating at 4095.
- On hs_fall with h_seen=1: meas_h_total <= h_phase+1 and h_err <= (h_phase+1 != H_TOTAL). h_seen is set on the first hs_fall.
- v_line (11 bit): +1 on each hs_fall, saturating at 2047.
- vs_fall sets vs_pending. A frame boundary is the first hs_fall with vs_pending=1, or with vs_fall in the same cycle. At a boundary:
  - v_line <= 0 and vs_pending is cleared.
  - meas_v_total <= v_line+1 and v_err <= (v_line+1 != V_TOTAL).
  - frame_start pulses in the next cycle.
- Outputs registered, 1-cycle latency from h_phase/v_line:
  - de = locked AND h_phase in [H_SYNC+H_BACK, H_SYNC+H_BACK+H_VISIBLE-1] AND v_line in [V_SYNC+V_BACK, V_SYNC+V_BACK+V_VISIBLE-1].
  - x_pos = h_phase-(H_SYNC+H_BACK); y_pos = v_line-(V_SYNC+V_BACK). Both hold their last value when de=0.
- bad_frame flag: set by any hs_fall yielding h_err; cleared at each boundary after it is evaluated.
- FSM:
  - UNLOCKED: on the first boundary go to CHECKING with good_cnt=0. The first boundary's measurement is ignored.
  - CHECKING: at each boundary, if the v total is good and bad_frame=0 (including the line that closes this frame), good_cnt+1; otherwise good_cnt=0. When good_cnt reaches LOCK_FRAMES go to LOCKED; locked=1 from the next cycle.
  - LOCKED: any hs_fall with a bad line length, a boundary with v_err, or h_phase reaching 4095 -> UNLOCKED; locked=0 and de=0 from the next cycle.
  - h_phase saturation in CHECKING also returns to UNLOCKED.
- vs_fall with no following hsync: vs_pending is held until the next hsync or until timeout.
- Reset mid-frame: immediate return to reset state; relock requires 1 + LOCK_FRAMES boundaries.
- Error flags are not sticky: each measurement overwrites them.

Test Plan:
- Nominal stream from the timing generator (800x525) -> meas 800/525, h_err=v_err=0, locked rises 1 cycle after the 3rd boundary; per locked frame de high 640x480 cycles, x 0..639, y 0..479.
- One line stretched to 801 clocks while locked -> h_err=1 and meas_h_total=801 the cycle after that hs_fall, locked=0 next cycle; locked returns after 3 further clean boundaries.
- Frame of 526 lines while locked -> v_err=1, meas_v_total=526, unlock; the next 525-line frame clears v_err.
- hsync held high 4096+ clocks -> h_phase saturates, locked=0, de=0, no spurious frame_start.
- vsync and hsync falling in the same cycle, and vsync falling mid-line -> the boundary lands on that hs_fall (respectively the next one); y_pos counts stay correct.
- Assert reset during the active region of a locked frame -> all outputs 0 immediately, no false edge on release, relock after 3 boundaries.
